mem_bridge: RTL and testbench
=============================

# mem_bridge

Multi-cycle memory bridge between the multi-cycle MIPS datapath and a word-organised synchronous SRAM. It accepts the datapath's level-held read/write requests (address, write data, MemRd/MemWr), runs the SRAM access with a programmable number of wait states and returns read data with a one-cycle ready pulse. While an access is in flight it asserts a stall to the control unit. The block sits directly downstream of the datapath's memory port, in the position of the zero-latency instruction/data memory.

## Interface
- ADDR_W, 10: SRAM word-address width; the SRAM holds 2^ADDR_W 32-bit words.
- WAIT_CYC, 2: extra SRAM wait states per access, range 0..15.

- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- CpuAddr  in  32  byte address from the IorD address mux.
- CpuMemRd  in  1  read request; held high until CpuReady is seen.
- CpuMemWr  in  1  write request; held high until CpuReady is seen.
- CpuWd  in  32  write data from the B register.
- CpuRd  out  32  read data; valid while CpuReady=1 and held until the next read completes.
- CpuReady  out  1  one-cycle completion pulse.
- CpuStall  out  1  high while a request is pending and not yet completed.
- AlignErr  out  1  sticky misaligned-access flag.
- SramAddr  out  ADDR_W  word address, CpuAddr[ADDR_W+1:2].
- SramCe  out  1  SRAM chip enable.
- SramWe  out  1  SRAM write enable.
- SramWd  out  32  SRAM write data.
- SramRd  in  32  SRAM read data; valid in the last ACCESS cycle.

## Operation
- FSM states:
  - IDLE
    - If CpuMemWr=1, or CpuMemRd=1, and CpuAddr[1:0]=0:
      - Latch the address, write data and operation.
      - Write has priority when both requests are high.
      - Load the wait counter with WAIT_CYC and go to ACCESS.
    - If a request is high and CpuAddr[1:0]≠0:
      - Set AlignErr.
      - Go to DONE without any SRAM activity; the read-data register is loaded with 0 for reads.
    - Otherwise stay in IDLE.
  - ACCESS
    - Drive SramCe=1, with SramAddr and SramWd taken from the latched values.
    - SramWe=1 on writes.
    - When the counter reaches 0:
      - On a read, capture SramRd into the read-data register.
      - Go to DONE.
    - Otherwise decrement the counter.
  - DONE
    - CpuReady=1 for exactly one cycle, then return to IDLE.
- CpuStall = (state==ACCESS) or (state==IDLE and (CpuMemRd or CpuMemWr)). It is 0 in DONE.
- The requester must drop its request in the cycle after CpuReady. A request still high in the IDLE cycle that follows DONE is treated as a new access.
- Request inputs are sampled only in IDLE. Changes during ACCESS or DONE are ignored.
- Address bits above ADDR_W+1 are ignored: addresses wrap modulo the SRAM size, with no error.
- AlignErr stays at 1 until Reset.
- CpuRd changes only on read completion. Writes leave it unchanged.

## Timing
- Reset values:
  - State IDLE.
  - CpuRd=0, CpuReady=0, AlignErr=0.
  - SramCe=0, SramWe=0, SramAddr=0, SramWd=0.
  - Counter=0.
- CpuStall follows its combinational definition, so it is 1 during reset only if a request is high.
- Latency: with the request first sampled in IDLE in cycle 0:
  - ACCESS occupies cycles 1..WAIT_CYC+1.
  - CpuReady is high in cycle WAIT_CYC+2.
  - Total latency is WAIT_CYC+2 cycles; WAIT_CYC=0 gives 2 cycles.
- Misaligned request: CpuReady is high in cycle 1.
- Back-to-back: a new request can be accepted in the IDLE cycle following DONE, giving a throughput of one access per WAIT_CYC+3 cycles.
- Reset mid-access:
  - The Reset edge returns the FSM to IDLE and clears every output.
  - SramCe and SramWe are 0 in the following cycle.
  - The aborted access never produces CpuReady.
  - A write may have partially occurred in the SRAM; no guarantee is made about the SRAM contents.

## Test plan
- Reset with CpuMemRd=1 held -> all registered outputs 0 and no SramCe while Reset=1. First CpuReady arrives WAIT_CYC+2 cycles after Reset drops.
- WAIT_CYC=2: write 0xDEADBEEF to 0x0000_0010, then read 0x10 -> SramAddr=4 and SramWe=1 for 3 cycles on the write. Read returns CpuRd=0xDEADBEEF with CpuReady in cycle 4 and CpuStall high in cycles 0–3.
- Misaligned read at 0x0000_0013 -> no SramCe, CpuReady in cycle 1, CpuRd=0, AlignErr=1, and AlignErr still 1 after a later aligned access.
- Both CpuMemRd and CpuMemWr high at 0x8 with CpuWd=0x1234 -> a write is performed (SramWe=1), and CpuRd keeps its previous value.
- WAIT_CYC=0: read 0x4 and then 0x8 back-to-back with the request held -> CpuReady in cycles 2 and 5, with no duplicate access.
- Reset asserted in the second ACCESS cycle of a read -> SramCe=0 in the next cycle, no CpuReady ever issued, and CpuRd=0.

Source files
------------

// File: rtl/mem_bridge_if.sv
// Bundles the datapath memory port and the SRAM port of mem_bridge.
// The slave modport is the bridge's view; master is the datapath/SRAM side.
interface mem_bridge_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [31:0]       CpuAddr;
  logic              CpuMemRd;
  logic              CpuMemWr;
  logic [31:0]       CpuWd;
  logic [31:0]       CpuRd;
  logic              CpuReady;
  logic              CpuStall;
  logic              AlignErr;
  logic [ADDR_W-1:0] SramAddr;
  logic              SramCe;
  logic              SramWe;
  logic [31:0]       SramWd;
  logic [31:0]       SramRd;

  modport slave (
    input  CpuAddr, CpuMemRd, CpuMemWr, CpuWd, SramRd,
    output CpuRd, CpuReady, CpuStall, AlignErr, SramAddr, SramCe, SramWe, SramWd
  );

  modport master (
    output CpuAddr, CpuMemRd, CpuMemWr, CpuWd, SramRd,
    input  CpuRd, CpuReady, CpuStall, AlignErr, SramAddr, SramCe, SramWe, SramWd
  );
endinterface

// File: rtl/mem_bridge.sv
// Multi-cycle bridge from the MIPS datapath memory port to a word-organised SRAM,
// with programmable wait states, a one-cycle ready pulse and a stall to control.
module mem_bridge #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic         Clock,
  input  logic         Reset,
  mem_bridge_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYC);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       rd_q, rd_d;
  logic              ready_q, ready_d;
  logic              ce_q, ce_d;
  logic              we_q, we_d;
  logic              align_err_q, align_err_d;

  logic req;
  logic aligned;

  assign req     = bus.CpuMemRd | bus.CpuMemWr;
  assign aligned = (bus.CpuAddr[1:0] == 2'b00);

  // Upper address bits wrap silently onto the SRAM.
  logic unused_addr;
  assign unused_addr = ^bus.CpuAddr[31:ADDR_W+2];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    wd_d        = wd_q;
    rd_d        = rd_q;
    ready_d     = 1'b0;
    ce_d        = ce_q;
    we_d        = we_q;
    align_err_d = align_err_q;

    case (state_q)
      StIdle: begin
        if (req) begin
          if (aligned) begin
            // Write wins when both requests are raised together.
            is_wr_d = bus.CpuMemWr;
            addr_d  = bus.CpuAddr[ADDR_W+1:2];
            wd_d    = bus.CpuWd;
            cnt_d   = WaitInit;
            ce_d    = 1'b1;
            we_d    = bus.CpuMemWr;
            state_d = StAccess;
          end else begin
            align_err_d = 1'b1;
            if (!bus.CpuMemWr) begin
              rd_d = '0;
            end
            ready_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          if (!is_wr_q) begin
            rd_d = bus.SramRd;
          end
          ce_d    = 1'b0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      wd_q        <= '0;
      rd_q        <= '0;
      ready_q     <= 1'b0;
      ce_q        <= 1'b0;
      we_q        <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      rd_q        <= rd_d;
      ready_q     <= ready_d;
      ce_q        <= ce_d;
      we_q        <= we_d;
      align_err_q <= align_err_d;
    end
  end

  assign bus.CpuStall = (state_q == StAccess) || ((state_q == StIdle) && req);
  assign bus.CpuRd    = rd_q;
  assign bus.CpuReady = ready_q;
  assign bus.AlignErr = align_err_q;
  assign bus.SramAddr = addr_q;
  assign bus.SramCe   = ce_q;
  assign bus.SramWe   = we_q;
  assign bus.SramWd   = wd_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Bench for mem_bridge: one instance with two wait states, one with none, each
// attached to a simple SRAM, checked against a transaction-level memory model.
module tb_mem_bridge;

  localparam int unsigned AW = 10;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  mem_bridge_if #(.ADDR_W(AW)) bus_a ();
  mem_bridge_if #(.ADDR_W(AW)) bus_b ();

  mem_bridge #(.ADDR_W(AW), .WAIT_CYC(2)) dut_a (.Clock(Clock), .Reset(Reset), .bus(bus_a));
  mem_bridge #(.ADDR_W(AW), .WAIT_CYC(0)) dut_b (.Clock(Clock), .Reset(Reset), .bus(bus_b));

  logic [31:0] addr = '0;
  logic [31:0] wd = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  int          sel = 0;

  assign bus_a.CpuAddr  = addr;
  assign bus_a.CpuWd    = wd;
  assign bus_a.CpuMemRd = rd && (sel == 0);
  assign bus_a.CpuMemWr = wr && (sel == 0);
  assign bus_b.CpuAddr  = addr;
  assign bus_b.CpuWd    = wd;
  assign bus_b.CpuMemRd = rd && (sel == 1);
  assign bus_b.CpuMemWr = wr && (sel == 1);

  logic [31:0] sram_a [1024];
  logic [31:0] sram_b [1024];
  always @(posedge Clock) begin
    if (bus_a.SramCe && bus_a.SramWe) sram_a[bus_a.SramAddr] <= bus_a.SramWd;
    if (bus_b.SramCe && bus_b.SramWe) sram_b[bus_b.SramAddr] <= bus_b.SramWd;
  end
  assign bus_a.SramRd = sram_a[bus_a.SramAddr];
  assign bus_b.SramRd = sram_b[bus_b.SramAddr];

  logic          o_ready, o_stall, o_ae, o_ce, o_we;
  logic [31:0]   o_rd, o_swd;
  logic [AW-1:0] o_saddr;
  assign o_ready = (sel == 0) ? bus_a.CpuReady : bus_b.CpuReady;
  assign o_stall = (sel == 0) ? bus_a.CpuStall : bus_b.CpuStall;
  assign o_ae    = (sel == 0) ? bus_a.AlignErr : bus_b.AlignErr;
  assign o_ce    = (sel == 0) ? bus_a.SramCe   : bus_b.SramCe;
  assign o_we    = (sel == 0) ? bus_a.SramWe   : bus_b.SramWe;
  assign o_rd    = (sel == 0) ? bus_a.CpuRd    : bus_b.CpuRd;
  assign o_swd   = (sel == 0) ? bus_a.SramWd   : bus_b.SramWd;
  assign o_saddr = (sel == 0) ? bus_a.SramAddr : bus_b.SramAddr;

  // Reference model: word store keyed by (instance, word index) plus expected CPU-side state.
  bit [31:0] ref_mem [int];
  int        waitc [2] = '{2, 0};
  bit [31:0] exp_rd [2] = '{32'h0, 32'h0};
  bit        rd_known [2] = '{1'b1, 1'b1};
  bit        exp_ae [2] = '{1'b0, 1'b0};

  int checks = 0;
  int errors = 0;

  function automatic int mkey(input int s, input logic [31:0] a);
    return s * 4096 + int'(a[AW+1:2]);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One complete access, started at a negedge in an idle cycle; ends in the next idle cycle.
  task automatic do_access(input int s, input bit w, input bit r, input logic [31:0] a,
                           input logic [31:0] d);
    bit mis;
    int cyc, ce_cnt, we_cnt, exp_acc;
    mis = (a[1:0] != 2'b00);
    exp_acc = mis ? 0 : waitc[s] + 1;
    sel = s; addr = a; wd = d; wr = w; rd = r;
    #1 check("stall_cycle0", 32'(o_stall), 32'd1);
    cyc = 0; ce_cnt = 0; we_cnt = 0;
    do begin
      @(negedge Clock);
      cyc++;
      if (o_ce) begin
        ce_cnt++;
        check("sram_addr", 32'(o_saddr), 32'(a[AW+1:2]));
        if (w) check("sram_wd", o_swd, d);
      end
      if (o_we) we_cnt++;
      if (!o_ready) check("stall_busy", 32'(o_stall), 32'd1);
    end while (!o_ready && cyc < 40);
    if (mis) begin
      exp_ae[s] = 1'b1;
      if (!w) begin
        exp_rd[s] = '0;
        rd_known[s] = 1'b1;
      end
    end else if (w) begin
      ref_mem[mkey(s, a)] = d;
    end else if (ref_mem.exists(mkey(s, a))) begin
      exp_rd[s] = ref_mem[mkey(s, a)];
      rd_known[s] = 1'b1;
    end else begin
      rd_known[s] = 1'b0;
    end
    check("latency", 32'(cyc), mis ? 32'd1 : 32'(waitc[s] + 2));
    check("ce_cycles", 32'(ce_cnt), 32'(exp_acc));
    check("we_cycles", 32'(we_cnt), (w && !mis) ? 32'(exp_acc) : 32'd0);
    check("stall_done", 32'(o_stall), 32'd0);
    check("align_err", 32'(o_ae), 32'(exp_ae[s]));
    if (rd_known[s]) check("cpu_rd", o_rd, exp_rd[s]);
    rd = 1'b0; wr = 1'b0;
    @(negedge Clock);
  endtask

  initial begin
    int n, c, ce_cnt, rc1, rc2, acc_ready;
    logic [31:0] a, d;
    bit w;

    // Reset with a read held on the two-wait-state instance.
    sel = 0; rd = 1'b1; addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("rst_ce", 32'(bus_a.SramCe), 32'd0);
      check("rst_stall", 32'(bus_a.CpuStall), 32'd1);
    end
    check("rst_ready", 32'(bus_a.CpuReady), 32'd0);
    check("rst_rd", bus_a.CpuRd, 32'd0);
    check("rst_ae", 32'(bus_a.AlignErr), 32'd0);
    check("rst_we", 32'(bus_a.SramWe), 32'd0);
    check("rst_saddr", 32'(bus_a.SramAddr), 32'd0);
    check("rst_swd", bus_a.SramWd, 32'd0);
    check("rst_b_ce", 32'(bus_b.SramCe), 32'd0);
    Reset = 1'b0;
    do_access(0, 1'b0, 1'b1, 32'h0, 32'h0);

    // Write then read back with two wait states.
    do_access(0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
    do_access(0, 1'b0, 1'b1, 32'h10, 32'h0);

    // Misaligned read, then a later aligned access keeps the sticky flag.
    do_access(0, 1'b0, 1'b1, 32'h13, 32'h0);
    do_access(0, 1'b1, 1'b0, 32'h20, 32'h0BAD_F00D);

    // Simultaneous read and write requests: write wins, read data untouched.
    do_access(0, 1'b0, 1'b1, 32'h10, 32'h0);
    do_access(0, 1'b1, 1'b1, 32'h8, 32'h1234);
    do_access(0, 1'b0, 1'b1, 32'h8, 32'h0);

    // Aliased write via high address bits, then back-to-back reads with zero wait states.
    do_access(1, 1'b1, 1'b0, 32'hFFF0_0004, 32'hA5A5_5A5A);
    do_access(1, 1'b1, 1'b0, 32'h8, 32'h7777_0008);
    sel = 1; addr = 32'h4; rd = 1'b1; wr = 1'b0;
    n = 0; ce_cnt = 0; rc1 = 0; rc2 = 0;
    for (c = 1; c <= 8; c++) begin
      @(negedge Clock);
      if (bus_b.SramCe) ce_cnt++;
      if (bus_b.CpuReady) begin
        if (n == 0) begin
          rc1 = c;
          check("b2b_rd1", bus_b.CpuRd, ref_mem[mkey(1, 32'h4)]);
          addr = 32'h8;
        end else begin
          rc2 = c;
          check("b2b_rd2", bus_b.CpuRd, ref_mem[mkey(1, 32'h8)]);
          rd = 1'b0;
        end
        n++;
      end
    end
    check("b2b_ready_count", 32'(n), 32'd2);
    check("b2b_ready1_cycle", 32'(rc1), 32'd2);
    check("b2b_ready2_cycle", 32'(rc2), 32'd5);
    check("b2b_accesses", 32'(ce_cnt), 32'd2);
    exp_rd[1] = ref_mem[mkey(1, 32'h8)];
    rd_known[1] = 1'b1;

    // Random traffic on both instances.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      if (i < 12) a[AW+1:2] = AW'($urandom_range(0, 7));
      else a[AW+1:2] = AW'($urandom_range(0, 11));
      d = $urandom;
      w = (i < 12) || ($urandom_range(0, 2) == 0);
      do_access(int'($urandom_range(0, 1)), w, ~w | ($urandom_range(0, 3) == 0), a, d);
    end

    // Reset in the second access cycle of a read.
    sel = 0; addr = 32'h10; rd = 1'b1; wr = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check("abort_ce_before", 32'(bus_a.SramCe), 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    check("abort_ce", 32'(bus_a.SramCe), 32'd0);
    check("abort_we", 32'(bus_a.SramWe), 32'd0);
    check("abort_rd", bus_a.CpuRd, 32'd0);
    check("abort_ae", 32'(bus_a.AlignErr), 32'd0);
    acc_ready = int'(bus_a.CpuReady);
    rd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      if (i == 1) Reset = 1'b0;
      acc_ready += int'(bus_a.CpuReady);
    end
    check("abort_no_ready", 32'(acc_ready), 32'd0);
    check("abort_rd_after", bus_a.CpuRd, 32'd0);
    exp_rd = '{32'h0, 32'h0};
    rd_known = '{1'b1, 1'b1};
    exp_ae = '{1'b0, 1'b0};
    do_access(0, 1'b0, 1'b1, 32'h10, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed no finish expected finish before 200000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
